// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//
// Holds the architectural fetch PC and offers it to the fetch consumer on a
// valid/ready handshake. Redirect channels are prioritised so that channel 0
// wins. Also covers a boot delay after reset or clear, halt/resume control,
// rejection of misaligned redirect targets, and a fetch counter that wraps.
//
// Optional feature: define PC_GEN_RVC_EN for compressed-instruction support.
// That adds the fetch_len16 input (step of 2 instead of 4) and relaxes the
// alignment check to target[0]==0. Without it the step is always 4 and
// targets must have target[1:0]==0.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   clear         synchronous flush to RESET_VEC / BOOT
//   halt_req      request to stop fetching
//   resume        leave HALTED
//   redir_valid   per-channel redirect strobe (index 0 highest priority)
//   redir_target  channel i target in bits [i*XLEN +: XLEN]
//   fetch_ready   consumer accepts the current request
//   fetch_len16   (PC_GEN_RVC_EN only) accepted instruction is 16 bits
//   fetch_valid   fetch request valid (state == RUN)
//   fetch_pc      PC of the current request
//   misalign_err  one-cycle pulse: a misaligned redirect was rejected
//   err_addr      last rejected target
//   halted        state == HALTED
//   fetch_cnt     completed handshakes, modulo 2^CNT_W
module pc_gen #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_VEC   = '0,
  parameter int               NUM_REDIR   = 3,
  parameter int               BOOT_CYCLES = 2,
  parameter int               CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      halt_req,
  input  logic                      resume,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target,
  input  logic                      fetch_ready,
`ifdef PC_GEN_RVC_EN
  input  logic                      fetch_len16,
`endif
  output logic                      fetch_valid,
  output logic [XLEN-1:0]           fetch_pc,
  output logic                      misalign_err,
  output logic [XLEN-1:0]           err_addr,
  output logic                      halted,
  output logic [CNT_W-1:0]          fetch_cnt
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     boot_cnt, boot_cnt_nxt;
  logic [XLEN-1:0]   pc, pc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              merr, merr_nxt;
  logic [XLEN-1:0]   eaddr, eaddr_nxt;

  logic              any_redir;
  logic [XLEN-1:0]   sel_target;
  logic              sel_misaligned;
  logic              handshake;
  logic [XLEN-1:0]   step;

  // Scan from the highest index down so the lowest asserted channel is the
  // last assignment and therefore wins.
  always_comb begin
    any_redir  = 1'b0;
    sel_target = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        any_redir  = 1'b1;
        sel_target = redir_target[i*XLEN +: XLEN];
      end
    end
  end

`ifdef PC_GEN_RVC_EN
  assign sel_misaligned = any_redir && sel_target[0];
  assign step           = fetch_len16 ? XLEN'(2) : XLEN'(4);
`else
  assign sel_misaligned = any_redir && (sel_target[1:0] != 2'b00);
  assign step           = XLEN'(4);
`endif

  assign handshake = (state == RUN) && fetch_ready;

  // Next-state logic. The handshake count is independent of the priority
  // chain: any accepted request is counted unless clear wipes the counter.
  // A legal redirect freezes the FSM (including the boot counter) for that
  // cycle, so a redirect during BOOT simply stretches the boot delay.
  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    pc_nxt       = pc;
    cnt_nxt      = cnt;
    merr_nxt     = 1'b0;
    eaddr_nxt    = eaddr;

    if (handshake) begin
      cnt_nxt = cnt + 1'b1;
    end

    if (clear) begin
      state_nxt    = BOOT;
      boot_cnt_nxt = '0;
      pc_nxt       = RESET_VEC;
      cnt_nxt      = '0;
      eaddr_nxt    = '0;
    end else if (sel_misaligned) begin
      merr_nxt  = 1'b1;
      eaddr_nxt = sel_target;
      state_nxt = HALTED;
    end else if (any_redir) begin
      pc_nxt = sel_target;
    end else begin
      if (handshake) begin
        pc_nxt = pc + step;
      end
      case (state)
        BOOT: begin
          if (boot_cnt == BOOT_LAST) begin
            state_nxt = RUN;
          end else begin
            boot_cnt_nxt = boot_cnt + 1'b1;
          end
        end
        RUN: begin
          if (halt_req) begin
            state_nxt = HALTED;
          end
        end
        HALTED: begin
          if (resume && !halt_req) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      boot_cnt <= '0;
      pc       <= RESET_VEC;
      cnt      <= '0;
      merr     <= 1'b0;
      eaddr    <= '0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      pc       <= pc_nxt;
      cnt      <= cnt_nxt;
      merr     <= merr_nxt;
      eaddr    <= eaddr_nxt;
    end
  end

  assign fetch_valid  = (state == RUN);
  assign halted       = (state == HALTED);
  assign fetch_pc     = pc;
  assign fetch_cnt    = cnt;
  assign misalign_err = merr;
  assign err_addr     = eaddr;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen (RESET_VEC=0x100, BOOT_CYCLES=2,
// CNT_W=4 so the fetch counter wraps within the run). Stimulus pushes the
// reference model's expected outputs into a queue; a monitor pops one entry
// after every rising edge and compares. Directed scenarios come first, with
// a few absolute-value anchors, followed by a randomized phase.
module tb_pc_gen;

  localparam int XLEN  = 32;
  localparam int NR    = 3;
  localparam int BOOTC = 2;
  localparam int CW    = 4;
  localparam logic [31:0] RVEC = 32'h100;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic            clk;
  logic            reset;
  logic            clear;
  logic            halt_req;
  logic            resume;
  logic [NR-1:0]   redir_valid;
  logic [NR*XLEN-1:0] redir_target;
  logic            fetch_ready;
  logic            fetch_len16;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            misalign_err;
  logic [XLEN-1:0] err_addr;
  logic            halted;
  logic [CW-1:0]   fetch_cnt;

  pc_gen #(
    .XLEN(XLEN), .RESET_VEC(RVEC), .NUM_REDIR(NR),
    .BOOT_CYCLES(BOOTC), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .halt_req(halt_req),
    .resume(resume),
    .redir_valid(redir_valid),
    .redir_target(redir_target),
    .fetch_ready(fetch_ready),
`ifdef PC_GEN_RVC_EN
    .fetch_len16(fetch_len16),
`endif
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .misalign_err(misalign_err),
    .err_addr(err_addr),
    .halted(halted),
    .fetch_cnt(fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        halted;
    logic        merr;
    logic [31:0] eaddr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: fetch mode, cycles elapsed in boot, and plain values.
  int          m_mode;
  int          m_boot_elapsed;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_merr;
  logic [31:0] m_eaddr;

  function automatic bit isMisaligned(input logic [31:0] t);
`ifdef PC_GEN_RVC_EN
    return (t % 2) != 0;
`else
    return (t % 4) != 0;
`endif
  endfunction

  function automatic void modelReset();
    m_mode = M_BOOT;
    m_boot_elapsed = 0;
    m_pc = RVEC;
    m_cnt = 0;
    m_merr = 0;
    m_eaddr = 32'h0;
  endfunction

  function automatic void modelStep(input logic rst, input logic clr,
                                    input logic hreq, input logic res,
                                    input logic [NR-1:0] rv,
                                    input logic [NR*XLEN-1:0] rt,
                                    input logic rdy, input logic len16);
    bit hs;
    int win;
    logic [31:0] tgt;
    if (rst) begin
      modelReset();
      return;
    end
    hs = (m_mode == M_RUN) && rdy;
    win = -1;
    tgt = 32'h0;
    for (int i = 0; i < NR; i++) begin
      if (rv[i]) begin
        win = i;
        tgt = rt[i*XLEN +: XLEN];
        break;
      end
    end
    m_merr = 0;
    if (hs) m_cnt = (m_cnt + 1) % (1 << CW);
    if (clr) begin
      modelReset();
    end else if (win >= 0 && isMisaligned(tgt)) begin
      m_merr = 1;
      m_eaddr = tgt;
      m_mode = M_HALT;
    end else if (win >= 0) begin
      m_pc = tgt;
    end else begin
`ifdef PC_GEN_RVC_EN
      if (hs) m_pc = m_pc + (len16 ? 32'd2 : 32'd4);
`else
      if (hs) m_pc = m_pc + 32'd4;
`endif
      if (m_mode == M_BOOT) begin
        m_boot_elapsed++;
        if (m_boot_elapsed == BOOTC) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (hreq) m_mode = M_HALT;
      end else if (res && !hreq) begin
        m_mode = M_RUN;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the model
  // says the outputs must be after the following rising edge.
  task automatic applyStimulus(input logic rst, input logic clr,
                               input logic hreq, input logic res,
                               input logic [NR-1:0] rv,
                               input logic [NR*XLEN-1:0] rt,
                               input logic rdy);
    exp_t e;
    @(negedge clk);
    reset = rst;
    clear = clr;
    halt_req = hreq;
    resume = res;
    redir_valid = rv;
    redir_target = rt;
    fetch_ready = rdy;
    modelStep(rst, clr, hreq, res, rv, rt, rdy, fetch_len16);
    e.valid  = (m_mode == M_RUN);
    e.pc     = m_pc;
    e.cnt    = m_cnt;
    e.halted = (m_mode == M_HALT);
    e.merr   = m_merr;
    e.eaddr  = m_eaddr;
    sb.push_back(e);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, '0, '0, rdy);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.valid});
        checkOutput("fetch_pc", fetch_pc, e.pc);
        checkOutput("fetch_cnt", {28'b0, fetch_cnt}, e.cnt);
        checkOutput("halted", {31'b0, halted}, {31'b0, e.halted});
        checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, e.merr});
        checkOutput("err_addr", err_addr, e.eaddr);
      end
    end
  end

  initial begin
    logic [NR*XLEN-1:0] rt;
    logic [NR-1:0]      rv;
    logic [31:0]        t;
    logic [31:0]        bad;

    reset = 1'b1;
    clear = 1'b0;
    halt_req = 1'b0;
    resume = 1'b0;
    redir_valid = '0;
    redir_target = '0;
    fetch_ready = 1'b0;
    fetch_len16 = 1'b0;
    modelReset();
`ifdef PC_GEN_RVC_EN
    bad = 32'h2001;
`else
    bad = 32'h2002;
`endif

    // Reset held, then release with ready high: two boot cycles, two handshakes.
    applyStimulus(1, 0, 0, 0, '0, '0, 1);
    applyStimulus(1, 0, 0, 0, '0, '0, 1);
    idle(1, 4);
    settle();
    checkOutput("anchor_pc_after_boot", fetch_pc, 32'h108);
    checkOutput("anchor_cnt_after_boot", {28'b0, fetch_cnt}, 32'd2);

    // Consumer stalls: pc and count hold.
    idle(0, 4);
    settle();
    checkOutput("anchor_pc_stall", fetch_pc, 32'h108);
    idle(1, 1);
    settle();
    checkOutput("anchor_pc_resume_seq", fetch_pc, 32'h10C);

    // Two redirects plus handshake: ch1 wins, handshake counted.
    applyStimulus(0, 0, 0, 0, 3'b110, {32'h3000, 32'h2000, 32'h0}, 1);
    settle();
    checkOutput("anchor_redir_pc", fetch_pc, 32'h2000);
    checkOutput("anchor_redir_cnt", {28'b0, fetch_cnt}, 32'd4);

    // Misaligned redirect on ch0: pulse, halt, pc kept; then resume.
    applyStimulus(0, 0, 0, 0, 3'b001, {64'h0, bad}, 0);
    settle();
    checkOutput("anchor_err_addr", err_addr, bad);
    checkOutput("anchor_err_pc", fetch_pc, 32'h2000);
    idle(0, 1);
    applyStimulus(0, 0, 0, 1, '0, '0, 0);
    idle(1, 2);

    // Halt, debug write in HALTED, resume at the new pc; halt+resume stays halted.
    applyStimulus(0, 0, 1, 0, '0, '0, 0);
    applyStimulus(0, 0, 0, 0, 3'b100, {32'h4000, 64'h0}, 0);
    applyStimulus(0, 0, 1, 1, '0, '0, 0);
    applyStimulus(0, 0, 0, 1, '0, '0, 0);
    settle();
    checkOutput("anchor_debug_pc", fetch_pc, 32'h4000);
    idle(1, 3);

    // Clear mid-stream, handshake in the same cycle is discarded.
    applyStimulus(0, 1, 0, 0, 3'b001, {64'h0, 32'h5000}, 1);
    settle();
    checkOutput("anchor_clear_pc", fetch_pc, RVEC);
    checkOutput("anchor_clear_cnt", {28'b0, fetch_cnt}, 32'd0);
    idle(0, 2);

    // Wrap-around of pc at the top of the address space.
    applyStimulus(0, 0, 0, 0, 3'b010, {32'h0, 32'hFFFF_FFFC, 32'h0}, 0);
    idle(1, 1);
    settle();
    checkOutput("anchor_pc_wrap", fetch_pc, 32'h0);
    idle(1, 20);

`ifdef PC_GEN_RVC_EN
    applyStimulus(0, 0, 0, 0, 3'b001, {64'h0, 32'h10}, 0);
    fetch_len16 = 1'b1;
    idle(1, 1);
    fetch_len16 = 1'b0;
    settle();
    checkOutput("anchor_rvc_step", fetch_pc, 32'h12);
    applyStimulus(0, 0, 0, 0, 3'b001, {64'h0, 32'h21}, 0);
    applyStimulus(0, 0, 0, 1, '0, '0, 0);
    applyStimulus(0, 0, 0, 0, 3'b001, {64'h0, 32'h22}, 0);
    settle();
    checkOutput("anchor_rvc_aligned", fetch_pc, 32'h22);
`endif

    // Randomized phase.
    for (int n = 0; n < 1500; n++) begin
      for (int ch = 0; ch < NR; ch++) begin
        t = $urandom;
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
        rt[ch*XLEN +: XLEN] = t;
        rv[ch] = ($urandom_range(9) == 0);
      end
      fetch_len16 = 1'($urandom_range(1));
      applyStimulus($urandom_range(199) == 0, $urandom_range(99) == 0,
                    $urandom_range(19) == 0, $urandom_range(3) == 0,
                    rv, rt, $urandom_range(9) < 7);
    end

    settle();
    settle();
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
